// File: rtl/spi_flash_pkg.sv
// Shared SPI NOR-flash definitions.
// Opcodes, responder states and address width.
package spi_flash_pkg;

  localparam int ADDR_BITS = 24;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_RDID = 8'h9F;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    ID,
    IGNORE
  } state_t;

endpackage

// File: rtl/spi_flash_responder_if.sv
// SPI bus between the flash reader and a flash device.
// Mode 3: sclk idles high, cs active low.
interface spi_flash_responder_if;

  logic spi_cs;
  logic spi_sclk;
  logic spi_mosi;
  logic spi_miso;

  modport master (
    output spi_cs,
    output spi_sclk,
    output spi_mosi,
    input  spi_miso
  );

  modport slave (
    input  spi_cs,
    input  spi_sclk,
    input  spi_mosi,
    output spi_miso
  );

endinterface

// File: rtl/spi_flash_store.sv
// Backing byte array for the flash responder.
// Host write port, combinational flash-address read.
module spi_flash_store
  import spi_flash_pkg::*;
#(
  parameter int              DEPTH     = 256,
  parameter int              AW        = $clog2(DEPTH),
  parameter logic [23:0]     BASE_ADDR = 24'h100000
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [7:0]           wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [7:0]           rd_data
);

  logic [7:0]           mem [DEPTH];
  logic [ADDR_BITS-1:0] off;
  logic                 hit;

  // Host byte write, visible the next cycle.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Below-base addresses wrap to huge offsets, so one
  // unsigned compare covers both ends of the window.
  always_comb begin
    off     = rd_addr - BASE_ADDR;
    hit     = off < ADDR_BITS'(DEPTH);
    rd_data = hit ? mem[off[AW-1:0]] : 8'hFF;
  end

endmodule

// File: rtl/spi_flash_responder.sv
// SPI NOR-flash responder serving READ and RDID.
// Runs on the master's clock; sclk edges found by sampling.
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int          DEPTH     = 256,
  parameter int          AW        = $clog2(DEPTH),
  parameter logic [23:0] BASE_ADDR = 24'h100000,
  parameter logic [23:0] JEDEC_ID  = 24'hEF4016
) (
  input  logic                 clk,
  input  logic                 reset_n,
  spi_flash_responder_if.slave spi,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [7:0]           wr_data,
  output logic                 active,
  output logic                 cmd_done
);

  state_t               state;
  logic                 sclk_q;
  logic [4:0]           bit_cnt;
  logic [7:0]           rx_shift;
  logic [7:0]           tx_shift;
  logic [ADDR_BITS-1:0] addr;
  logic [1:0]           id_idx;

  logic                 rise;
  logic [7:0]           rx_next;
  logic [ADDR_BITS-1:0] addr_next;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [7:0]           rd_data;
  logic [7:0]           id_byte;

  // Final address rise reads the byte at the just-completed
  // address, before addr itself has been updated.
  always_comb begin
    rise      = spi.spi_sclk & ~sclk_q & ~spi.spi_cs;
    rx_next   = {rx_shift[6:0], spi.spi_mosi};
    addr_next = {addr[ADDR_BITS-2:0], spi.spi_mosi};
    rd_addr   = (state == ADDR) ? addr_next : addr;
    unique case (id_idx)
      2'd1:    id_byte = JEDEC_ID[15:8];
      2'd2:    id_byte = JEDEC_ID[7:0];
      default: id_byte = 8'hFF;
    endcase
  end

  assign spi.spi_miso = tx_shift[7];
  assign active       = (state != IDLE);

  spi_flash_store #(
    .DEPTH     (DEPTH),
    .AW        (AW),
    .BASE_ADDR (BASE_ADDR)
  ) u_store (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Command/address/data sequencer, one step per sclk rise.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      sclk_q   <= 1'b1;
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= 8'hFF;
      addr     <= '0;
      id_idx   <= '0;
      cmd_done <= 1'b0;
    end else begin
      sclk_q   <= spi.spi_sclk;
      cmd_done <= 1'b0;
      if (spi.spi_cs) begin
        state    <= IDLE;
        bit_cnt  <= '0;
        tx_shift <= 8'hFF;
        cmd_done <= (state == DATA) || (state == ID);
      end else if (rise) begin
        unique case (state)
          IDLE: begin
            rx_shift <= rx_next;
            bit_cnt  <= 5'd1;
            state    <= CMD;
          end
          CMD: begin
            rx_shift <= rx_next;
            if (bit_cnt == 5'd7) begin
              bit_cnt <= '0;
              unique case (1'b1)
                (rx_next == CMD_READ): state <= ADDR;
                (rx_next == CMD_RDID): begin
                  state    <= ID;
                  tx_shift <= JEDEC_ID[23:16];
                  id_idx   <= 2'd1;
                end
                default: state <= IGNORE;
              endcase
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          ADDR: begin
            if (bit_cnt == 5'd23) begin
              bit_cnt  <= '0;
              tx_shift <= rd_data;
              addr     <= addr_next + 24'd1;
              state    <= DATA;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
              addr    <= addr_next;
            end
          end
          DATA: begin
            if (bit_cnt == 5'd7) begin
              bit_cnt  <= '0;
              tx_shift <= rd_data;
              addr     <= addr + 24'd1;
            end else begin
              bit_cnt  <= bit_cnt + 5'd1;
              tx_shift <= {tx_shift[6:0], 1'b1};
            end
          end
          ID: begin
            if (bit_cnt == 5'd7) begin
              bit_cnt  <= '0;
              tx_shift <= id_byte;
              if (id_idx != 2'd3) begin
                id_idx <= id_idx + 2'd1;
              end
            end else begin
              bit_cnt  <= bit_cnt + 5'd1;
              tx_shift <= {tx_shift[6:0], 1'b1};
            end
          end
          IGNORE: begin
            tx_shift <= 8'hFF;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
